uart_rx_fsm: RTL and testbench

- Frame controller of the UART receiver.
- Sits between the RX line and the sampling, deserialising and checking stages.
- Tracks start, data, parity and stop bits using an oversampling edge counter and a bit counter.
- Drives the enables for the data sampler, deserializer and parity checker, consumes their results, and emits per-frame DATA_VALID and error strobes.

---
 rtl/uart_rx_fsm_if.sv | 46 ++++
 rtl/uart_rx_fsm.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Bundle between the UART RX frame controller and its line, sampler, deserializer and parity checker.
// With UART_RX_ERR_CNT_EN defined, also carries the error counter and its clear.
interface uart_rx_fsm_if #(
  parameter int unsigned PRESCALE_WIDTH = 6
);
  logic                      rx_in;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      par_en;
  logic                      sampled_bit;
  logic                      par_err;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [3:0]                bit_cnt;
  logic                      dat_samp_en;
  logic                      deser_en;
  logic                      par_chk_en;
  logic                      data_valid;
  logic                      stp_err;
  logic                      par_err_flag;
  logic                      strt_glitch;
`ifdef UART_RX_ERR_CNT_EN
  logic                      err_cnt_clr;
  logic [7:0]                err_cnt;

  modport master (
    output rx_in, prescale, par_en, sampled_bit, par_err, err_cnt_clr,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
           data_valid, stp_err, par_err_flag, strt_glitch, err_cnt
  );
  modport slave (
    input  rx_in, prescale, par_en, sampled_bit, par_err, err_cnt_clr,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
           data_valid, stp_err, par_err_flag, strt_glitch, err_cnt
  );
`else
  modport master (
    output rx_in, prescale, par_en, sampled_bit, par_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
           data_valid, stp_err, par_err_flag, strt_glitch
  );
  modport slave (
    input  rx_in, prescale, par_en, sampled_bit, par_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, par_chk_en,
           data_valid, stp_err, par_err_flag, strt_glitch
  );
`endif
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver frame controller: start/data/parity/stop tracking with per-frame result strobes.
// Optional saturating error counter enabled by defining UART_RX_ERR_CNT_EN.
module uart_rx_fsm #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 6
) (
  input logic          clk,
  input logic          rst_n,
  uart_rx_fsm_if.slave rx_if
);

  localparam int unsigned PW = PRESCALE_WIDTH;
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] edge_q, edge_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          par_en_q, par_en_d;
  logic          par_flag_q, par_flag_d;
  logic          stp_flag_q, stp_flag_d;
  logic          dat_samp_en_q, dat_samp_en_d;
  logic          deser_en_q, deser_en_d;
  logic          par_chk_en_q, par_chk_en_d;
  logic          data_valid_q, data_valid_d;
  logic          stp_err_q, stp_err_d;
  logic          par_err_flag_q, par_err_flag_d;
  logic          strt_glitch_q, strt_glitch_d;

  logic [PW-1:0] mid, last, samp_pt, chk_pt, edge_inc;
  logic          wrap, frame_end;

  // Bit timing derived from the ratio captured at frame start
  assign mid      = presc_q >> 1;
  assign last     = presc_q - PW'(1);
  assign samp_pt  = mid + PW'(2);
  assign chk_pt   = mid + PW'(3);
  assign wrap     = (edge_q == last);
  assign edge_inc = wrap ? '0 : edge_q + PW'(1);

  always_comb begin
    state_d       = state_q;
    edge_d        = edge_q;
    bit_d         = bit_q;
    presc_d       = presc_q;
    par_en_d      = par_en_q;
    par_flag_d    = par_flag_q;
    stp_flag_d    = stp_flag_q;
    strt_glitch_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        edge_d     = '0;
        bit_d      = '0;
        presc_d    = rx_if.prescale;
        par_en_d   = rx_if.par_en;
        par_flag_d = 1'b0;
        stp_flag_d = 1'b0;
        if (!rx_if.rx_in) state_d = S_START;
      end
      S_START: begin
        edge_d = edge_inc;
        if (edge_q == samp_pt && rx_if.sampled_bit) begin
          strt_glitch_d = 1'b1;
          state_d       = S_IDLE;
          edge_d        = '0;
          bit_d         = '0;
        end else if (wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        edge_d = edge_inc;
        if (wrap) begin
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        edge_d = edge_inc;
        // Checker result is registered one cycle after its enable
        if (edge_q == chk_pt) par_flag_d = rx_if.par_err;
        if (wrap) state_d = S_STOP;
      end
      S_STOP: begin
        edge_d = edge_inc;
        if (edge_q == samp_pt) stp_flag_d = !rx_if.sampled_bit;
        if (wrap) begin
          state_d    = S_IDLE;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Strobes are decoded from next-state values so the registered copies line up with EDGE_CNT
  assign frame_end = (state_q == S_STOP) && (state_d == S_STOP) && (edge_d == last);

  always_comb begin
    dat_samp_en_d  = (state_d != S_IDLE);
    deser_en_d     = (state_d == S_DATA)   && (edge_d == samp_pt);
    par_chk_en_d   = (state_d == S_PARITY) && (edge_d == samp_pt);
    data_valid_d   = frame_end && !stp_flag_d && !par_flag_q;
    stp_err_d      = frame_end && stp_flag_d;
    par_err_flag_d = frame_end && par_flag_q;
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_inc;

  // A frame with both stop and parity errors counts once
  assign err_inc = strt_glitch_d | stp_err_d | par_err_flag_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (rx_if.err_cnt_clr)                  err_cnt_d = '0;
    else if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  assign rx_if.err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      edge_q         <= '0;
      bit_q          <= '0;
      presc_q        <= '0;
      par_en_q       <= 1'b0;
      par_flag_q     <= 1'b0;
      stp_flag_q     <= 1'b0;
      dat_samp_en_q  <= 1'b0;
      deser_en_q     <= 1'b0;
      par_chk_en_q   <= 1'b0;
      data_valid_q   <= 1'b0;
      stp_err_q      <= 1'b0;
      par_err_flag_q <= 1'b0;
      strt_glitch_q  <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
      err_cnt_q      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      edge_q         <= edge_d;
      bit_q          <= bit_d;
      presc_q        <= presc_d;
      par_en_q       <= par_en_d;
      par_flag_q     <= par_flag_d;
      stp_flag_q     <= stp_flag_d;
      dat_samp_en_q  <= dat_samp_en_d;
      deser_en_q     <= deser_en_d;
      par_chk_en_q   <= par_chk_en_d;
      data_valid_q   <= data_valid_d;
      stp_err_q      <= stp_err_d;
      par_err_flag_q <= par_err_flag_d;
      strt_glitch_q  <= strt_glitch_d;
`ifdef UART_RX_ERR_CNT_EN
      err_cnt_q      <= err_cnt_d;
`endif
    end
  end

  assign rx_if.edge_cnt     = edge_q;
  assign rx_if.bit_cnt      = bit_q;
  assign rx_if.dat_samp_en  = dat_samp_en_q;
  assign rx_if.deser_en     = deser_en_q;
  assign rx_if.par_chk_en   = par_chk_en_q;
  assign rx_if.data_valid   = data_valid_q;
  assign rx_if.stp_err      = stp_err_q;
  assign rx_if.par_err_flag = par_err_flag_q;
  assign rx_if.strt_glitch  = strt_glitch_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: table-driven frames with a result scoreboard,
// plus hand-written glitch, back-to-back, mid-frame reset and error-counter sequences.
module tb_uart_rx_fsm;

  localparam int unsigned PW = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic stub_perr;

  always #5 clk = ~clk;

  uart_rx_fsm_if #(.PRESCALE_WIDTH(PW)) bus ();

  uart_rx_fsm #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (bus)
  );

  // Ideal sampler: the line value itself; the stub checker registers its answer after each enable
  assign bus.sampled_bit = bus.rx_in;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              bus.par_err <= 1'b0;
    else if (bus.par_chk_en) bus.par_err <= stub_perr;
  end

  typedef struct {
    logic [3:0] flags;   // {data_valid, stp_err, par_err_flag, strt_glitch}
    int         dcnt;
    int         pcnt;
    int         lat;
    int         mid;
    logic [7:0] data;
    bit         chk_data;
  } exp_t;

  typedef struct {
    int         presc;
    bit         par_en;
    logic [7:0] data;
    bit         stop;
    bit         perr;
    logic [2:0] res;     // {data_valid, stp_err, par_err_flag}
  } vec_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int          dcnt = 0;
  int          pcnt = 0;
  logic [7:0]  shreg = '0;
  logic        samp_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pulse counting, sample-point checks and scoreboard pops
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] act;
    if (!rst_n) begin
      dcnt      = 0;
      pcnt      = 0;
      samp_prev = 1'b0;
    end else begin
      if (bus.dat_samp_en && !samp_prev) begin
        start_cyc = cyc;
        dcnt      = 0;
        pcnt      = 0;
      end
      samp_prev = bus.dat_samp_en;
      if (bus.deser_en) begin
        dcnt++;
        shreg = {bus.sampled_bit, shreg[7:1]};
        if (sb_q.size() > 0) check("deser_edge", int'(bus.edge_cnt), sb_q[0].mid + 2);
      end
      if (bus.par_chk_en) begin
        pcnt++;
        if (sb_q.size() > 0) check("parchk_edge", int'(bus.edge_cnt), sb_q[0].mid + 2);
      end
      act = {bus.data_valid, bus.stp_err, bus.par_err_flag, bus.strt_glitch};
      if (act != 4'b0000) begin
        if (sb_q.size() == 0) begin
          check("unexpected_pulse", int'(act), 0);
        end else begin
          e = sb_q.pop_front();
          check("result_flags", int'(act), int'(e.flags));
          check("deser_cnt", dcnt, e.dcnt);
          check("parchk_cnt", pcnt, e.pcnt);
          check("latency", int'(cyc - start_cyc), e.lat);
          if (e.chk_data) check("deser_data", int'(shreg), int'(e.data));
          if (e.flags[0]) begin
            check("glitch_edge_cnt", int'(bus.edge_cnt), 0);
            check("glitch_samp_en", int'(bus.dat_samp_en), 0);
          end
        end
      end
    end
  end

  // Caller is 1 time unit after a rising edge; returns the same way, right after the stop bit
  task automatic drive_frame(input vec_t v);
    exp_t        e;
    logic [11:0] line;
    int          nb;
    line      = '1;
    line[0]   = 1'b0;
    line[8:1] = v.data;
    if (v.par_en) begin
      line[9]  = ^v.data;
      line[10] = v.stop;
      nb       = 11;
    end else begin
      line[9] = v.stop;
      nb      = 10;
    end
    e.flags    = {v.res, 1'b0};
    e.dcnt     = 8;
    e.pcnt     = v.par_en ? 1 : 0;
    e.lat      = v.presc * nb - 1;
    e.mid      = v.presc / 2;
    e.data     = v.data;
    e.chk_data = 1'b1;
    sb_q.push_back(e);
    stub_perr    = v.perr;
    bus.prescale = PW'(v.presc);
    bus.par_en   = v.par_en;
    for (int k = 0; k < nb; k++) begin
      bus.rx_in = line[k];
      if (k == 1) begin
        bus.par_en   = !v.par_en;
        bus.prescale = (v.presc == 8) ? PW'(16) : PW'(8);
      end
      repeat (v.presc) @(posedge clk);
      #1;
    end
    bus.rx_in = 1'b1;
  endtask

  task automatic wait_sb(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("scoreboard_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic glitch(input int presc);
    exp_t e;
    e.flags      = 4'b0001;
    e.dcnt       = 0;
    e.pcnt       = 0;
    e.lat        = presc / 2 + 3;
    e.mid        = presc / 2;
    e.data       = '0;
    e.chk_data   = 1'b0;
    sb_q.push_back(e);
    bus.prescale = PW'(presc);
    bus.rx_in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.rx_in = 1'b1;
    wait_sb(4 * presc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    vec_t b2b;
    logic [7:0] rst_line;
    vecs[0] = '{presc: 8,  par_en: 1'b1, data: 8'hA5, stop: 1'b1, perr: 1'b0, res: 3'b100};
    vecs[1] = '{presc: 8,  par_en: 1'b1, data: 8'hA5, stop: 1'b0, perr: 1'b0, res: 3'b010};
    vecs[2] = '{presc: 8,  par_en: 1'b1, data: 8'hA5, stop: 1'b1, perr: 1'b1, res: 3'b001};
    vecs[3] = '{presc: 16, par_en: 1'b0, data: 8'h3C, stop: 1'b1, perr: 1'b0, res: 3'b100};
    vecs[4] = '{presc: 32, par_en: 1'b1, data: 8'h5A, stop: 1'b0, perr: 1'b1, res: 3'b011};
    vecs[5] = '{presc: 32, par_en: 1'b0, data: 8'h00, stop: 1'b1, perr: 1'b1, res: 3'b100};
    vecs[6] = '{presc: 16, par_en: 1'b1, data: 8'hFF, stop: 1'b1, perr: 1'b0, res: 3'b100};
    vecs[7] = '{presc: 8,  par_en: 1'b0, data: 8'hC3, stop: 1'b0, perr: 1'b0, res: 3'b010};

    rst_n        = 1'b0;
    bus.rx_in    = 1'b1;
    bus.prescale = PW'(8);
    bus.par_en   = 1'b0;
    stub_perr    = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
    bus.err_cnt_clr = 1'b0;
`endif
    #1;
    check("reset_outputs", int'({bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.deser_en,
                                 bus.par_chk_en, bus.data_valid, bus.stp_err,
                                 bus.par_err_flag, bus.strt_glitch}), 0);
`ifdef UART_RX_ERR_CNT_EN
    check("reset_err_cnt", int'(bus.err_cnt), 0);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive_frame(vecs[i]);
      wait_sb(4 * vecs[i].presc);
    end

    glitch(8);
    glitch(16);

    // Two frames with no idle gap between stop and the next start bit
    b2b = '{presc: 16, par_en: 1'b0, data: 8'h3C, stop: 1'b1, perr: 1'b0, res: 3'b100};
    drive_frame(b2b);
    b2b.data = 8'hFF;
    drive_frame(b2b);
    wait_sb(64);

    // Reset while the fifth data bit is being received
    rst_line     = 8'h96;
    bus.prescale = PW'(8);
    bus.par_en   = 1'b1;
    bus.rx_in    = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      bus.rx_in = rst_line[k];
      repeat ((k == 4) ? 4 : 8) @(posedge clk);
      #1;
    end
    check("pre_reset_bit_cnt", int'(bus.bit_cnt), 4);
    check("pre_reset_samp_en", int'(bus.dat_samp_en), 1);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs", int'({bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.deser_en,
                                          bus.par_chk_en, bus.data_valid, bus.stp_err,
                                          bus.par_err_flag, bus.strt_glitch}), 0);
    bus.rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    check("post_reset_idle", int'(bus.dat_samp_en), 0);

`ifdef UART_RX_ERR_CNT_EN
    bus.err_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_cnt_clr = 1'b0;
    check("err_cnt_cleared", int'(bus.err_cnt), 0);
    for (int g = 0; g < 3; g++) glitch(8);
    check("err_cnt_three", int'(bus.err_cnt), 3);
    bus.err_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.err_cnt_clr = 1'b0;
    check("err_cnt_clear_again", int'(bus.err_cnt), 0);
`endif

    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
